// File: rtl/uart_hex_pkg.sv
// Shared types and helpers for the UART hex-record transmitter: serialiser
// states, line terminator codes and the nibble-to-ASCII mapping.
package uart_hex_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    // 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push when full or a pop when
// empty is ignored. DEPTH must be a power of two so the pointers wrap freely.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LEVEL_FULL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_hex_streamer.sv
// Buffered UART transmitter: each queued DATA_W-bit record goes out as
// uppercase hex digits (MSB nibble first) plus LF or CR+LF, 8N1.
module uart_hex_streamer
    import uart_hex_pkg::*;
#(
    parameter int CLK_FREQ   = 200_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int CRLF       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             data,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          dropped,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx,
    output logic                          busy,
    output logic [1:0]                    state_dbg
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int NCHAR        = DATA_W / 4;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int CIW          = $clog2(NCHAR + 2);
    localparam bit USE_CRLF     = (CRLF != 0);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CIW-1:0] NCHAR_I   = CIW'(NCHAR);
    localparam logic [CIW-1:0] LAST_CHAR = CIW'(NCHAR + (USE_CRLF ? 1 : 0));

    generate
        if ((DATA_W % 4) != 0 || DATA_W < 4) begin : g_bad_data_w
            $error("uart_hex_streamer: DATA_W must be a multiple of 4 and >= 4");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_hex_streamer: FIFO_DEPTH must be a power of 2 and >= 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_hex_streamer: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

    tx_state_t         state;
    logic [CW-1:0]     clk_count;
    logic [2:0]        bit_idx;
    logic [CIW-1:0]    char_idx;
    logic [DATA_W-1:0] record_reg;
    logic [7:0]        tx_byte;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              bit_done;
    logic [DATA_W-1:0] shifted;
    logic [CIW-1:0]    next_idx;
    logic [7:0]        next_byte;

    // Handshake: a word transfers on a rising edge where data_valid && data_ready;
    // data_ready depends only on the stored level, never on data_valid.
    assign data_ready = !fifo_full;
    assign push       = data_valid && data_ready;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign busy       = (state != IDLE) || (fifo_level != '0);
    assign bit_done   = (clk_count == BIT_LAST);
    assign state_dbg  = state;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The record shifts left one nibble per character, so the next digit is
    // always the top nibble of the shifted value.
    always_comb begin
        shifted   = record_reg << 4;
        next_idx  = char_idx + 1'b1;
        next_byte = ASCII_LF;
        if (next_idx < NCHAR_I)
            next_byte = nibble_to_ascii(shifted[DATA_W-1 -: 4]);
        else if (next_idx == NCHAR_I && USE_CRLF)
            next_byte = ASCII_CR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            dropped    <= 1'b0;
            clk_count  <= '0;
            bit_idx    <= '0;
            char_idx   <= '0;
            record_reg <= '0;
            tx_byte    <= '0;
        end else begin
            dropped <= data_valid && !data_ready;

            // Line level follows the state one cycle later, so each bit keeps
            // its full CLKS_PER_BIT width.
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= tx_byte[bit_idx];
                default: tx <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        record_reg <= fifo_rdata;
                        tx_byte    <= nibble_to_ascii(fifo_rdata[DATA_W-1 -: 4]);
                        char_idx   <= '0;
                        clk_count  <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        clk_count <= '0;
                        bit_idx   <= '0;
                        state     <= DATA;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        clk_count <= '0;
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        clk_count <= '0;
                        if (char_idx < LAST_CHAR) begin
                            char_idx   <= next_idx;
                            record_reg <= shifted;
                            tx_byte    <= next_byte;
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_streamer.sv
// Directed bench for uart_hex_streamer: three instances (40-bit LF, 16-bit CR+LF,
// and a fast 8-bit one for the random soak) with a cycle-exact line decoder.
`timescale 1ns/1ps
module tb_uart_hex_streamer;

    localparam int CPB_AB = 16;
    localparam int CPB_C  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [39:0] data_a;
    logic        valid_a, ready_a, dropped_a, tx_a, busy_a;
    logic [2:0]  level_a;
    logic [1:0]  st_a;

    logic [15:0] data_b;
    logic        valid_b, ready_b, dropped_b, tx_b, busy_b;
    logic [2:0]  level_b;
    logic [1:0]  st_b;

    logic [7:0]  data_c;
    logic        valid_c, ready_c, dropped_c, tx_c, busy_c;
    logic [1:0]  level_c;
    logic [1:0]  st_c;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] word_q[$];
    bit rx_timeout = 1'b0;

    uart_hex_streamer #(.CLK_FREQ(16), .BAUD(1), .DATA_W(40), .FIFO_DEPTH(4), .CRLF(0)) dut (
        .clk(clk), .rst(rst), .data(data_a), .data_valid(valid_a), .data_ready(ready_a),
        .dropped(dropped_a), .fifo_level(level_a), .tx(tx_a), .busy(busy_a), .state_dbg(st_a));

    uart_hex_streamer #(.CLK_FREQ(16), .BAUD(1), .DATA_W(16), .FIFO_DEPTH(4), .CRLF(1)) dut_b (
        .clk(clk), .rst(rst), .data(data_b), .data_valid(valid_b), .data_ready(ready_b),
        .dropped(dropped_b), .fifo_level(level_b), .tx(tx_b), .busy(busy_b), .state_dbg(st_b));

    uart_hex_streamer #(.CLK_FREQ(4), .BAUD(1), .DATA_W(8), .FIFO_DEPTH(2), .CRLF(0)) dut_c (
        .clk(clk), .rst(rst), .data(data_c), .data_valid(valid_c), .data_ready(ready_c),
        .dropped(dropped_c), .fifo_level(level_c), .tx(tx_c), .busy(busy_c), .state_dbg(st_c));

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 150000 cycles");
        $fatal(1, "watchdog");
    end

    function automatic logic line(input int sel);
        if (sel == 0) return tx_a;
        if (sel == 1) return tx_b;
        return tx_c;
    endfunction

    // Expected characters of one record, appended to exp_q.
    task automatic add_record(input logic [39:0] w, input int nchar, input bit crlf);
        logic [3:0] nib;
        for (int i = 0; i < nchar; i++) begin
            nib = 4'(w >> (4 * (nchar - 1 - i)));
            exp_q.push_back((nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h41 + {4'h0, nib} - 8'd10));
        end
        if (crlf) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Entered at a negedge; counts idle samples before the start bit, then
    // requires every bit to hold one level for exactly cpb samples.
    task automatic rx_char(input int sel, output logic [7:0] c, output int gap, output bit tok);
        int cpb;
        cpb = (sel == 2) ? CPB_C : CPB_AB;
        gap = 0;
        tok = 1'b1;
        c   = 8'h00;
        while (line(sel) !== 1'b0) begin
            if (gap >= 4000) begin
                gap = -1;
                tok = 1'b0;
                return;
            end
            gap++;
            @(negedge clk);
        end
        for (int b = 0; b < 10; b++) begin
            logic lvl;
            lvl = line(sel);
            for (int j = 0; j < cpb; j++) begin
                if (line(sel) !== lvl) tok = 1'b0;
                @(negedge clk);
            end
            if (b == 0 && lvl !== 1'b0) tok = 1'b0;
            if (b == 9 && lvl !== 1'b1) tok = 1'b0;
            if (b >= 1 && b <= 8) c[b-1] = lvl;
        end
    endtask

    task automatic rx_expect(input int sel, input int first_gap, input string name);
        logic [7:0] c, e;
        int gap, n, want_gap;
        bit tok;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            rx_char(sel, c, gap, tok);
            checks++;
            if (gap < 0) begin
                failures++;
                rx_timeout = 1'b1;
                $display("FAIL %s char %0d: no start bit seen, expected 0x%02h", name, i, e);
                exp_q.delete();
                return;
            end
            if (c !== e) begin
                failures++;
                $display("FAIL %s char %0d: got 0x%02h expected 0x%02h", name, i, c, e);
            end
            checks++;
            if (!tok) begin
                failures++;
                $display("FAIL %s char %0d timing: bit widths not %0d cycles", name, i,
                         (sel == 2) ? CPB_C : CPB_AB);
            end
            if (i != 0 || first_gap >= 0) begin
                want_gap = (i == 0) ? first_gap : 0;
                checks++;
                if (gap !== want_gap) begin
                    failures++;
                    $display("FAIL %s char %0d gap: got %0d idle cycles expected %0d", name, i, gap, want_gap);
                end
            end
        end
    endtask

    task automatic push_a(input logic [39:0] w);
        data_a  = w;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [15:0] w);
        data_b  = w;
        valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;
        repeat (3) @(negedge clk);
        checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL reset tx: got %b expected 1", tx_a); end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL reset data_ready: got %b expected 1", ready_a); end
        checks++; if (dropped_a !== 1'b0) begin failures++; $display("FAIL reset dropped: got %b expected 0", dropped_a); end
        checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL reset fifo_level: got %0d expected 0", level_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset busy: got %b expected 0", busy_a); end
        checks++; if (tx_b !== 1'b1 || tx_c !== 1'b1) begin failures++; $display("FAIL reset tx_bc: got %b%b expected 11", tx_b, tx_c); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_record;
        add_record(40'h0123456789, 10, 1'b0);
        push_a(40'h0123456789);
        checks++; if (level_a !== 3'd1) begin failures++; $display("FAIL single level: got %0d expected 1", level_a); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL single busy: got %b expected 1", busy_a); end
        rx_expect(0, 2, "single");
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL single busy_end: got %b expected 0", busy_a); end
    endtask

    task automatic test_hex_crlf;
        int n;
        add_record(40'hBEEF, 4, 1'b1);
        push_b(16'hBEEF);
        fork
            rx_expect(1, 2, "beef");
            begin
                n = 0;
                while (busy_b === 1'b1 && n < 3000) begin
                    n++;
                    @(negedge clk);
                end
                checks++;
                if (n !== 60 * CPB_AB + 1) begin
                    failures++;
                    $display("FAIL beef busy_len: got %0d cycles expected %0d", n, 60 * CPB_AB + 1);
                end
            end
        join
    endtask

    // A record is put in flight first so the burst lands on an occupied serialiser.
    task automatic test_burst_overflow;
        int lows;
        push_a(40'h1111111111);
        fork
            begin
                add_record(40'h1111111111, 10, 1'b0);
                rx_expect(0, 2, "burst_lead");
                for (int k = 0; k < 4; k++) begin
                    add_record(40'h0A + 40'(k), 10, 1'b0);
                    rx_expect(0, 1, "burst_rec");
                end
            end
            begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    data_a  = 40'h0A + 40'(k);
                    valid_a = 1'b1;
                    @(negedge clk);
                    checks++;
                    if (level_a !== 3'((k < 4) ? k + 1 : 4)) begin
                        failures++; $display("FAIL burst level %0d: got %0d expected %0d", k, level_a, (k < 4) ? k + 1 : 4);
                    end
                    checks++;
                    if (ready_a !== ((k < 3) ? 1'b1 : 1'b0)) begin
                        failures++; $display("FAIL burst ready %0d: got %b expected %b", k, ready_a, (k < 3));
                    end
                    checks++;
                    if (dropped_a !== ((k == 4) ? 1'b1 : 1'b0)) begin
                        failures++; $display("FAIL burst dropped %0d: got %b expected %b", k, dropped_a, (k == 4));
                    end
                end
                valid_a = 1'b0;
                @(negedge clk);
                checks++; if (dropped_a !== 1'b0) begin failures++; $display("FAIL burst dropped_pulse: got %b expected 0", dropped_a); end
            end
        join
        lows = 0;
        repeat (300) begin
            if (tx_a !== 1'b1) lows++;
            @(negedge clk);
        end
        checks++; if (lows !== 0) begin failures++; $display("FAIL burst extra_record: %0d low cycles expected 0", lows); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL burst busy_end: got %b expected 0", busy_a); end
    endtask

    task automatic test_push_during_tx;
        int n;
        push_a(40'hFFFFFFFFFF);
        fork
            begin
                add_record(40'hFFFFFFFFFF, 10, 1'b0);
                rx_expect(0, 2, "ff_rec");
                add_record(40'h0000000001, 10, 1'b0);
                rx_expect(0, 1, "one_rec");
            end
            begin
                checks++; if (level_a !== 3'd1) begin failures++; $display("FAIL trace level0: got %0d expected 1", level_a); end
                @(negedge clk);
                checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL trace level1: got %0d expected 0", level_a); end
                repeat (60) @(negedge clk);
                data_a  = 40'h0000000001;
                valid_a = 1'b1;
                @(negedge clk);
                valid_a = 1'b0;
                checks++; if (level_a !== 3'd1) begin failures++; $display("FAIL trace level2: got %0d expected 1", level_a); end
                n = 0;
                while (level_a !== 3'd0 && n < 3000) begin
                    n++;
                    @(negedge clk);
                end
                checks++; if (n >= 3000) begin failures++; $display("FAIL trace level3: got %0d expected 0", level_a); end
            end
        join
    endtask

    task automatic test_reset_mid_frame;
        int lows, busies;
        data_a = 40'h0123456789; valid_a = 1'b1; @(negedge clk);
        data_a = 40'h2222222222; @(negedge clk);
        data_a = 40'h3333333333; @(negedge clk);
        valid_a = 1'b0;
        checks++; if (level_a !== 3'd2) begin failures++; $display("FAIL midrst queued: got %0d expected 2", level_a); end
        repeat (230) @(negedge clk);
        checks++; if (tx_a !== 1'b0) begin failures++; $display("FAIL midrst bit3: got %b expected 0", tx_a); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL midrst tx: got %b expected 1", tx_a); end
        checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL midrst level: got %0d expected 0", level_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL midrst busy: got %b expected 0", busy_a); end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL midrst ready: got %b expected 1", ready_a); end
        lows = 0; busies = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx_a !== 1'b1) lows++;
            if (busy_a !== 1'b0) busies++;
        end
        checks++; if (lows !== 0 || busies !== 0) begin
            failures++; $display("FAIL midrst quiet: %0d low and %0d busy cycles expected 0", lows, busies);
        end
    endtask

    task automatic test_soak;
        int refused, drops, g;
        bit drive_done;
        logic [7:0] w;
        refused = 0; drops = 0; drive_done = 1'b0;
        word_q.delete();
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    g = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 200);
                    repeat (g) @(negedge clk);
                    data_c  = 8'($urandom_range(0, 255));
                    valid_c = 1'b1;
                    if (ready_c === 1'b1) word_q.push_back(data_c);
                    else refused++;
                    @(negedge clk);
                    valid_c = 1'b0;
                end
                repeat (3) @(negedge clk);
                drive_done = 1'b1;
            end
            begin
                while (!drive_done) begin
                    if (dropped_c === 1'b1) drops++;
                    @(negedge clk);
                end
            end
            begin
                while (!(drive_done && word_q.size() == 0) && !rx_timeout) begin
                    if (word_q.size() != 0) begin
                        w = word_q.pop_front();
                        add_record({32'h0, w}, 2, 1'b0);
                        rx_expect(2, -1, "soak");
                    end else begin
                        @(negedge clk);
                    end
                end
            end
        join
        checks++; if (drops !== refused) begin failures++; $display("FAIL soak drops: got %0d pulses expected %0d", drops, refused); end
        checks++; if (word_q.size() !== 0) begin failures++; $display("FAIL soak pending: got %0d words expected 0", word_q.size()); end
        repeat (5) @(negedge clk);
        checks++; if (busy_c !== 1'b0) begin failures++; $display("FAIL soak busy_end: got %b expected 0", busy_c); end
    endtask

    initial begin
        test_reset();
        test_single_record();
        test_hex_crlf();
        test_burst_overflow();
        test_push_during_tx();
        test_reset_mid_frame();
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_hex_streamer.md
# uart_hex_streamer

Buffered, parametrised UART hex-record transmitter. It accepts DATA_W-bit words through a valid/ready handshake into an internal FIFO. Each word is sent as DATA_W/4 uppercase ASCII hex digits (MSB nibble first), followed by LF or CR+LF, in 8N1 framing. It sits between the measurement core and the board TX pin, so bursts of results no longer stall or drop while a record is in flight.

## Interface
- CLK_FREQ, 200_000_000: clock frequency in Hz.
- BAUD, 115200: line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer truncation).
- DATA_W, 40: record width; must be a multiple of 4 and ≥4; NCHAR = DATA_W/4.
- FIFO_DEPTH, 4: record buffer depth; power of 2 and ≥2.
- CRLF, 0: 0 sends terminator LF (0x0A); 1 sends CR (0x0D) then LF.
- clk, input, 1: single clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- data, input, DATA_W: record to send.
- data_valid, input, 1: data is offered this cycle.
- data_ready, output, 1: FIFO not full; a transfer occurs on a rising edge with data_valid && data_ready.
- dropped, output, 1: one-cycle pulse, asserted the cycle after data_valid was high while data_ready was low.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: number of stored records not yet popped.
- tx, output, 1: UART line, registered, idles high.
- busy, output, 1: high when the serialiser is not IDLE or fifo_level ≠ 0.

## Operation
- Reset values: tx=1, data_ready=1, dropped=0, fifo_level=0, busy=0. The FIFO is emptied and the serialiser goes to IDLE.
- Elaboration errors:
  - DATA_W%4≠0.
  - FIFO_DEPTH not a power of 2 or <2.
  - CLKS_PER_BIT<2.
- FIFO behaviour:
  - data_ready = (fifo_level < FIFO_DEPTH). It is combinational from the level register only, never from data_valid.
  - A push while full is refused even if a pop happens in the same cycle. The word is lost and dropped pulses.
  - A push and a pop in the same cycle when not full leave fifo_level unchanged.
- Serialiser states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If the FIFO is non-empty: pop into the 40-bit-style shift register (record_reg), set char_idx=0, load tx_byte, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: tx=tx_byte[bit_idx], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the last cycle, if more characters remain in the record: char_idx++, load the next tx_byte, go directly to START. There is no idle gap between characters.
  - Otherwise go to IDLE.
- Character sequence per record:
  - idx 0..NCHAR-1: hex digit of nibble data[DATA_W-1-4i -: 4]. Values 0–9 map to 0x30–0x39; 10–15 map to 0x41–0x46.
  - idx NCHAR: CR if CRLF=1, otherwise LF.
  - idx NCHAR+1 (CRLF=1 only): LF.
- A record's value is frozen at pop time. Later pushes never alter a record in flight.
- Reset mid-frame: on the cycle after rst is sampled high, tx=1 and all state takes its reset values. There is no frame completion and no pending-record recovery.

## Timing
- Bit period: exactly CLKS_PER_BIT clk cycles per start, data, or stop bit.
- Character period: 10·CLKS_PER_BIT cycles.
- Record period: (NCHAR+1+CRLF)·10·CLKS_PER_BIT cycles.
- Idle latency: with an empty FIFO and IDLE state, a word accepted at edge t is popped at edge t+1, and tx falls after edge t+2.
- Back-to-back records: one IDLE cycle (tx high) separates the last stop bit of one record from the next start bit.
- Counters:
  - clk_count is wide enough for CLKS_PER_BIT-1.
  - char_idx is $clog2(NCHAR+2) bits.
  - fifo pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- busy falls in the cycle the serialiser enters IDLE with fifo_level=0.

## Structure
- Package uart_hex_pkg holds:
  - the state enum (IDLE/START/DATA/STOP);
  - ASCII_LF=8'h0A and ASCII_CR=8'h0D;
  - function nibble_to_ascii(4-bit) -> 8-bit.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push/pop/level/full/empty with synchronous active-high reset. It is reusable elsewhere in the design.
- The top level contains the serialiser FSM, baud counter, character selection, and dropped generation.

## Test plan
All scenarios use CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16) unless noted.
- Single record: DATA_W=40, push 0x0123456789. The decoded line shows "0123456789\n" (11 chars). Every bit is exactly 16 cycles, and tx falls 2 cycles after acceptance.
- Hex letters with CR+LF: DATA_W=16, CRLF=1, push 0xBEEF. The line shows "BEEF\r\n", and busy drops after 60 bit periods.
- Burst and overflow: FIFO_DEPTH=4, push 5 words 0x000000000A..0x000000000E on consecutive cycles. data_ready goes low after the 4th push, dropped pulses once, and exactly 4 records emit, each separated by one idle cycle.
- Push during transmission: push 0xFFFFFFFFFF, then push 0x0000000001 mid-character. The first record stays intact, followed by "0000000001\n", and fifo_level traces 1→0→1→0.
- Reset mid-frame: assert rst during bit 3 of the 2nd character with 2 records queued. tx=1, fifo_level=0, busy=0 one cycle later, and no further start bit appears.
- Randomised soak: 200 random words with random valid gaps. The scoreboard matches every accepted word in order and counts dropped pulses equal to the refused words.
